dac_player: RTL and testbench
=============================

DAC_PLAYER -- requirements
Module: dac_player

Interface
REQ-001 Parameter sig_bits, default 8: width of the signed output sample and the stored sample.
REQ-002 Parameter time_bits, default 32: width of the unsigned time stamps and time_curr.
REQ-003 Parameter addr_bits, default 4: entry buffer depth is 2**addr_bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 time_curr  input  time_bits  current emulation time, unsigned, non-decreasing.
REQ-007 wr_valid  input  1  load-side entry valid.
REQ-008 wr_ready  output  1  load-side ready; equals not-full.
REQ-009 wr_time  input  time_bits  entry time stamp, unsigned.
REQ-010 wr_sig  input  signed sig_bits  entry value.
REQ-011 sig  output  signed sig_bits  played-back signal, registered, held between updates.
REQ-012 sig_upd  output  1  one-cycle pulse, high in the cycle sig takes a new entry value.
REQ-013 count  output  addr_bits+1  number of stored, unplayed entries.
REQ-014 empty  output  1  count == 0.
REQ-015 order_err  output  1  sticky: an accepted entry's wr_time was less than the previously accepted wr_time.

Function
REQ-016 Entries SHALL be held in a FIFO of 2**addr_bits (time, value) pairs, read in acceptance order.
REQ-017 An entry SHALL be accepted on a rising edge where wr_valid && wr_ready.
REQ-018 wr_ready SHALL be low exactly when count == 2**addr_bits; a pop in the same cycle does not raise wr_ready (no full bypass).
REQ-019 A pop SHALL occur on a rising edge where !empty && head.time <= time_curr, using an unsigned compare at full time_bits width.
REQ-020 On a pop, sig SHALL take head.value and sig_upd SHALL be 1 in the following cycle; latency from the qualifying time_curr to sig is one clock.
REQ-021 At most one entry SHALL pop per cycle; several due entries play on consecutive cycles in order.
REQ-022 With no pop, sig SHALL hold its value and sig_upd SHALL be 0.
REQ-023 An entry accepted while empty SHALL NOT pop in its acceptance cycle; earliest pop is the next edge (no empty bypass).
REQ-024 A simultaneous accept and pop SHALL leave count unchanged; pointers wrap modulo 2**addr_bits.
REQ-025 count SHALL never exceed 2**addr_bits or go below 0; empty pops and full accepts are impossible by construction.
REQ-026 order_err SHALL set on acceptance when wr_time < last accepted time; the entry is still stored. The flag clears only on reset. No compare is made on the first entry after reset.

Reset
REQ-027 On rst_n low, immediately and asynchronously: sig=0, sig_upd=0, count=0, empty=1, wr_ready=1, order_err=0, pointers=0, last-time register=0, first-entry flag set.
REQ-028 Reset mid-operation SHALL discard all stored entries; no pop or accept occurs while rst_n is low.
REQ-029 Deassertion SHALL take effect at the first clk rising edge after rst_n goes high; the bench synchronizes deassertion.

Verification
REQ-030 Defaults; load (10,5),(20,-3),(30,127); step time_curr by 1 per clk from 0. Required: sig=5 at the edge after time 10, -3 after 20, 127 after 30; exactly three sig_upd pulses; empty=1 at the end.
REQ-031 Load (1,1),(1,2),(1,3) with time_curr=100. Required: sig = 1, 2, 3 on three consecutive cycles.
REQ-032 addr_bits=2; push 5 entries with time 1000 while time_curr=0. Required: wr_ready=0 after 4 entries; count=4; the 5th entry is not accepted until a pop.
REQ-033 Push (50,9) then (40,7). Required: order_err=1 and remains set; both values play, 9 then 7, once time_curr >= 50.
REQ-034 Pulse rst_n low with 3 entries stored and sig=-3. Required: sig=0, count=0, empty=1, order_err=0 immediately, with no clk edge needed.
REQ-035 Run 200 cycles of random pushes and time advances against a reference queue model. Required: sig, count and sig_upd match the model every cycle, including pointer wrap and simultaneous push/pop.

Source files
------------

// File: rtl/dac_player.sv
// Time-stamped sample player: a FIFO of (time, value) entries whose head
// is driven onto sig once time_curr reaches the entry's time stamp.
module dac_player #(
    parameter int sig_bits  = 8,
    parameter int time_bits = 32,
    parameter int addr_bits = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [time_bits-1:0]        time_curr,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [time_bits-1:0]        wr_time,
    input  logic signed [sig_bits-1:0]  wr_sig,
    output logic signed [sig_bits-1:0]  sig,
    output logic                        sig_upd,
    output logic [addr_bits:0]          count,
    output logic                        empty,
    output logic                        order_err
);

    localparam int DEPTH = 2 ** addr_bits;
    localparam logic [addr_bits:0] FULL = (addr_bits + 1)'(DEPTH);

    logic [time_bits-1:0]       r_mem_t [DEPTH];
    logic signed [sig_bits-1:0] r_mem_v [DEPTH];

    logic [addr_bits-1:0]       r_wptr;
    logic [addr_bits-1:0]       r_rptr;
    logic [addr_bits:0]         r_count;
    logic signed [sig_bits-1:0] r_sig;
    logic                       r_upd;
    logic                       r_oerr;
    logic [time_bits-1:0]       r_last;
    logic                       r_first;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_ready;

    // Full and empty come from the registered count only, so a same-cycle
    // pop cannot make room and a same-cycle push cannot be played.
    assign w_empty = (r_count == '0);
    assign w_ready = (r_count != FULL);
    assign w_push  = wr_valid && w_ready;
    assign w_pop   = !w_empty && (r_mem_t[r_rptr] <= time_curr);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_t[r_wptr] <= wr_time;
            r_mem_v[r_wptr] <= wr_sig;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_sig   <= '0;
            r_upd   <= 1'b0;
            r_oerr  <= 1'b0;
            r_last  <= '0;
            r_first <= 1'b1;
        end else begin
            r_upd <= w_pop;
            if (w_pop) begin
                r_sig  <= r_mem_v[r_rptr];
                r_rptr <= r_rptr + addr_bits'(1);
            end
            if (w_push) begin
                r_wptr  <= r_wptr + addr_bits'(1);
                r_last  <= wr_time;
                r_first <= 1'b0;
                if (!r_first && (wr_time < r_last)) begin
                    r_oerr <= 1'b1;
                end
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (addr_bits + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (addr_bits + 1)'(1);
            end
        end
    end

    assign wr_ready  = w_ready;
    assign sig       = r_sig;
    assign sig_upd   = r_upd;
    assign count     = r_count;
    assign empty     = w_empty;
    assign order_err = r_oerr;

endmodule

// File: tb/tb_dac_player.sv
// Bench for dac_player: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_dac_player;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]       time_curr;
    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_time;
    logic signed [7:0] wr_sig;
    logic signed [7:0] sig;
    logic              sig_upd;
    logic [4:0]        count;
    logic              empty;
    logic              order_err;

    logic [31:0]       time2;
    logic              wr_valid2;
    logic              wr_ready2;
    logic [31:0]       wr_time2;
    logic signed [7:0] wr_sig2;
    logic signed [7:0] sig2;
    logic              sig_upd2;
    logic [2:0]        count2;
    logic              empty2;
    logic              order_err2;

    dac_player dut (
        .clk(clk), .rst_n(rst_n), .time_curr(time_curr),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_time(wr_time), .wr_sig(wr_sig),
        .sig(sig), .sig_upd(sig_upd), .count(count),
        .empty(empty), .order_err(order_err)
    );

    dac_player #(.addr_bits(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .time_curr(time2),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_time(wr_time2), .wr_sig(wr_sig2),
        .sig(sig2), .sig_upd(sig_upd2), .count(count2),
        .empty(empty2), .order_err(order_err2)
    );

    typedef struct {
        longint t;
        longint v;
    } ent_t;

    ent_t   q[$];
    longint m_sig;
    bit     m_upd;
    bit     m_oerr;
    bit     m_have;
    longint m_last;
    longint upd_v[$];
    int     upd_c[$];
    int     ncyc;
    int     n_cmp;
    int     n_bad;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sig  = 0;
        m_upd  = 0;
        m_oerr = 0;
        m_have = 0;
        m_last = 0;
    endtask

    // One clock of the main DUT, predicted from the queue model.
    task automatic step();
        bit     acc;
        bit     pp;
        longint t_in;
        longint v_in;
        acc  = wr_valid && (q.size() < 16);
        pp   = (q.size() > 0) && (q[0].t <= longint'(time_curr));
        t_in = longint'(wr_time);
        v_in = longint'(wr_sig);
        @(posedge clk);
        #1;
        ncyc++;
        m_upd = pp;
        if (pp) begin
            m_sig = q[0].v;
            void'(q.pop_front());
        end
        if (acc) begin
            if (m_have && t_in < m_last) m_oerr = 1;
            m_last = t_in;
            m_have = 1;
            q.push_back('{t_in, v_in});
        end
        chk("sig", longint'(sig), m_sig);
        chk("sig_upd", longint'(sig_upd), longint'(m_upd));
        chk("count", longint'(count), longint'(q.size()));
        chk("wr_ready", longint'(wr_ready), longint'(q.size() < 16));
        chk("empty", longint'(empty), longint'(q.size() == 0));
        chk("order_err", longint'(order_err), longint'(m_oerr));
        if (sig_upd) begin
            upd_v.push_back(longint'(sig));
            upd_c.push_back(ncyc);
        end
    endtask

    task automatic push(input longint t, input longint v);
        wr_valid = 1'b1;
        wr_time  = 32'(t);
        wr_sig   = 8'(v);
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int base;
        n_cmp = 0;
        n_bad = 0;
        ncyc  = 0;
        model_reset();
        rst_n     = 1'b0;
        time_curr = '0;
        wr_valid  = 1'b0;
        wr_time   = '0;
        wr_sig    = '0;
        time2     = '0;
        wr_valid2 = 1'b0;
        wr_time2  = '0;
        wr_sig2   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig", longint'(sig), 0);
        chk("rst_upd", longint'(sig_upd), 0);
        chk("rst_count", longint'(count), 0);
        chk("rst_empty", longint'(empty), 1);
        chk("rst_ready", longint'(wr_ready), 1);
        chk("rst_oerr", longint'(order_err), 0);
        rst_n = 1'b1;

        // Three entries, played as time_curr walks past each stamp
        base = upd_v.size();
        push(10, 5);
        push(20, -3);
        push(30, 127);
        for (int t = 0; t <= 40; t++) begin
            time_curr = 32'(t);
            step();
            if (t == 10) chk("play_t10", longint'(sig), 5);
            if (t == 20) chk("play_t20", longint'(sig), -3);
            if (t == 30) chk("play_t30", longint'(sig), 127);
        end
        chk("pulses3", longint'(upd_v.size() - base), 3);
        chk("end_empty", longint'(empty), 1);

        // Out-of-order stamp sets the sticky flag but still plays
        push(50, 9);
        push(40, 7);
        chk("oerr_set", longint'(order_err), 1);
        base = upd_v.size();
        for (int t = 41; t <= 55; t++) begin
            time_curr = 32'(t);
            step();
        end
        chk("ooo_n", longint'(upd_v.size() - base), 2);
        if (upd_v.size() - base == 2) begin
            chk("ooo_first", upd_v[base], 9);
            chk("ooo_second", upd_v[base + 1], 7);
            chk("ooo_consec", longint'(upd_c[base + 1] - upd_c[base]), 1);
        end
        chk("oerr_sticky", longint'(order_err), 1);

        // Already-due entries drain one per cycle
        time_curr = 32'd100;
        base = upd_v.size();
        push(1, 1);
        push(1, 2);
        push(1, 3);
        repeat (3) step();
        chk("due_n", longint'(upd_v.size() - base), 3);
        if (upd_v.size() - base == 3) begin
            chk("due_1", upd_v[base], 1);
            chk("due_2", upd_v[base + 1], 2);
            chk("due_3", upd_v[base + 2], 3);
            chk("due_consec", longint'(upd_c[base + 2] - upd_c[base]), 2);
        end

        // Asynchronous reset with entries stored
        push(100, -3);
        push(1000, 1);
        push(1000, 2);
        push(1000, 3);
        step();
        chk("pre_rst_sig", longint'(sig), -3);
        chk("pre_rst_count", longint'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sig", longint'(sig), 0);
        chk("arst_count", longint'(count), 0);
        chk("arst_empty", longint'(empty), 1);
        chk("arst_oerr", longint'(order_err), 0);
        chk("arst_ready", longint'(wr_ready), 1);
        model_reset();
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_noacc", longint'(count), 0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Small instance: fill to four, fifth waits for a pop
        wr_valid2 = 1'b1;
        wr_time2  = 32'd1000;
        for (int i = 1; i <= 6; i++) begin
            wr_sig2 = (i <= 4) ? 8'(i) : 8'sd5;
            step();
            if (i == 4) begin
                chk("d2_full_ready", longint'(wr_ready2), 0);
                chk("d2_full_count", longint'(count2), 4);
            end
        end
        chk("d2_hold_count", longint'(count2), 4);
        chk("d2_hold_ready", longint'(wr_ready2), 0);
        time2 = 32'd1000;
        step();
        chk("d2_pop1_sig", longint'(sig2), 1);
        chk("d2_pop1_count", longint'(count2), 3);
        step();
        wr_valid2 = 1'b0;
        chk("d2_acc5_count", longint'(count2), 3);
        chk("d2_pop2_sig", longint'(sig2), 2);
        repeat (3) step();
        chk("d2_last_sig", longint'(sig2), 5);
        chk("d2_drained", longint'(empty2), 1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 200; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_time  = time_curr + 32'($urandom_range(0, 24));
            wr_sig   = 8'($urandom);
            step();
            time_curr = time_curr + 32'($urandom_range(0, 2));
        end
        wr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
